// File: rtl/int_gen.sv
// int_gen: external-interrupt generator for the system-level CPU bench.
// A small FIFO holds trigger entries. Each entry is a word PC plus a delay.
// When the head PC matches the CPU macroscopic PC, the delay runs down and
// then `interrupt` is held until the CPU handler writes the acknowledge address.
module int_gen #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] INT_ADDR = 32'h0000_7F20,
   parameter int unsigned DLY_W    = 16,
   parameter int unsigned MAX_WAIT = 1000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_en,
   input  logic [31:0]                load_pc,
   input  logic [DLY_W-1:0]           load_delay,
   output logic                       load_ready,
   input  logic [31:0]                macroscopic_pc,
   input  logic [31:0]                m_int_addr,
   input  logic [3:0]                 m_int_byteen,
   output logic                       interrupt,
   output logic [$clog2(DEPTH+1)-1:0] pending_cnt,
   output logic [15:0]                ack_cnt,
   output logic                       overflow,
   output logic                       spurious_ack,
   output logic                       timeout
);

   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_DELAY,
      S_ASSERT
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [29:0]       fifo_pc  [DEPTH];
   logic [DLY_W-1:0]  fifo_dly [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt_nxt;

   logic [DLY_W-1:0]  dly_cnt;
   logic [DLY_W-1:0]  dly_nxt;
   logic [WAIT_W-1:0] wait_cnt;

   logic              ack;
   logic              push;
   logic              pop;
   logic              pc_match;
   logic [DLY_W-1:0]  head_dly;

   // Acknowledge decode, head-entry view and FIFO handshakes.
   always_comb begin
      ack        = (m_int_byteen != 4'b0000) && (m_int_addr[31:2] == INT_ADDR[31:2]);
      load_ready = (pending_cnt != FULL_CNT);
      push       = load_en && load_ready;
      pop        = ack && (state == S_ASSERT);
      pc_match   = (macroscopic_pc[31:2] == fifo_pc[rd_ptr]);
      head_dly   = fifo_dly[rd_ptr];
   end

   // Occupancy after this edge; push and pop together cancel.
   always_comb begin
      cnt_nxt = pending_cnt;
      if (push && !pop) begin
         cnt_nxt = pending_cnt + CNT_W'(1);
      end else if (pop && !push) begin
         cnt_nxt = pending_cnt - CNT_W'(1);
      end
   end

   // Next-state logic for the trigger sequencer.
   always_comb begin
      state_nxt = state;
      dly_nxt   = dly_cnt;
      case (state)
         S_IDLE: begin
            if (pending_cnt != '0) begin
               state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            if (pc_match) begin
               if (head_dly == '0) begin
                  state_nxt = S_ASSERT;
               end else begin
                  state_nxt = S_DELAY;
                  dly_nxt   = head_dly;
               end
            end
         end
         S_DELAY: begin
            dly_nxt = dly_cnt - DLY_W'(1);
            if (dly_cnt == DLY_W'(1)) begin
               state_nxt = S_ASSERT;
            end
         end
         S_ASSERT: begin
            if (ack) begin
               state_nxt = (cnt_nxt != '0) ? S_ARM : S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Sequencer state, delay counter and the registered interrupt line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         dly_cnt   <= '0;
         interrupt <= 1'b0;
      end else begin
         state     <= state_nxt;
         dly_cnt   <= dly_nxt;
         interrupt <= (state_nxt == S_ASSERT);
      end
   end

   // Trigger FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_pc[i]  <= '0;
            fifo_dly[i] <= '0;
         end
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pending_cnt <= '0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]  <= load_pc[31:2];
            fifo_dly[wr_ptr] <= load_delay;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         pending_cnt <= cnt_nxt;
      end
   end

   // Wait-for-acknowledge counter; timeout fires on the edge wait reaches MAX_WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else if ((state == S_ASSERT) && !ack) begin
         if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (wait_cnt >= WAIT_LAST) begin
            timeout <= 1'b1;
         end
      end else begin
         wait_cnt <= '0;
      end
   end

   // Acknowledge counter and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_cnt      <= '0;
         overflow     <= 1'b0;
         spurious_ack <= 1'b0;
      end else begin
         if (pop && (ack_cnt != '1)) begin
            ack_cnt <= ack_cnt + 16'd1;
         end
         if (load_en && !load_ready) begin
            overflow <= 1'b1;
         end
         if (ack && (state != S_ASSERT)) begin
            spurious_ack <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_int_gen.sv
// Directed bench for int_gen: a cycle-by-cycle vector table for the basic
// trigger/acknowledge flow, plus hand-written multi-cycle sequences.
module tb_int_gen;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned DLY_W    = 16;
   localparam int unsigned MAX_WAIT = 1000;
   localparam int unsigned NVEC     = 15;

   logic              clk;
   logic              reset;
   logic              load_en;
   logic [31:0]       load_pc;
   logic [DLY_W-1:0]  load_delay;
   logic              load_ready;
   logic [31:0]       macroscopic_pc;
   logic [31:0]       m_int_addr;
   logic [3:0]        m_int_byteen;
   logic              interrupt;
   logic [2:0]        pending_cnt;
   logic [15:0]       ack_cnt;
   logic              overflow;
   logic              spurious_ack;
   logic              timeout;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        le;
      logic [31:0] lpc;
      logic [15:0] ld;
      logic [31:0] mpc;
      logic [31:0] maddr;
      logic [3:0]  mbe;
      logic        e_int;
      logic [2:0]  e_cnt;
      logic [15:0] e_ack;
      logic        e_rdy;
      logic        e_ovf;
      logic        e_spur;
   } vec_t;

   vec_t vecs [NVEC];

   int_gen #(
      .DEPTH   (DEPTH),
      .INT_ADDR(32'h0000_7F20),
      .DLY_W   (DLY_W),
      .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .load_en       (load_en),
      .load_pc       (load_pc),
      .load_delay    (load_delay),
      .load_ready    (load_ready),
      .macroscopic_pc(macroscopic_pc),
      .m_int_addr    (m_int_addr),
      .m_int_byteen  (m_int_byteen),
      .interrupt     (interrupt),
      .pending_cnt   (pending_cnt),
      .ack_cnt       (ack_cnt),
      .overflow      (overflow),
      .spurious_ack  (spurious_ack),
      .timeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [15:0] d);
      load_en    = 1'b1;
      load_pc    = pc;
      load_delay = d;
      step();
      load_en    = 1'b0;
   endtask

   task automatic do_ack();
      m_int_addr   = 32'h0000_7F20;
      m_int_byteen = 4'b1111;
      step();
      m_int_byteen = 4'b0000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic set_vec(input int unsigned i, input logic le, input logic [31:0] lpc,
                          input logic [31:0] mpc, input logic [31:0] maddr, input logic [3:0] mbe,
                          input logic e_int, input logic [2:0] e_cnt, input logic [15:0] e_ack,
                          input logic e_spur);
      vecs[i].le     = le;
      vecs[i].lpc    = lpc;
      vecs[i].ld     = 16'd0;
      vecs[i].mpc    = mpc;
      vecs[i].maddr  = maddr;
      vecs[i].mbe    = mbe;
      vecs[i].e_int  = e_int;
      vecs[i].e_cnt  = e_cnt;
      vecs[i].e_ack  = e_ack;
      vecs[i].e_rdy  = 1'b1;
      vecs[i].e_ovf  = 1'b0;
      vecs[i].e_spur = e_spur;
   endtask

   initial begin
      //           i  le  lpc          mpc          maddr        mbe      int cnt ack spur
      set_vec( 0, 1, 32'h3010, 32'h3000, 32'h0000, 4'h0, 0, 1, 0, 0);
      set_vec( 1, 0, 32'h0000, 32'h3004, 32'h0000, 4'h0, 0, 1, 0, 0);
      set_vec( 2, 0, 32'h0000, 32'h3008, 32'h0000, 4'h0, 0, 1, 0, 0);
      set_vec( 3, 0, 32'h0000, 32'h300C, 32'h0000, 4'h0, 0, 1, 0, 0);
      set_vec( 4, 0, 32'h0000, 32'h3010, 32'h0000, 4'h0, 1, 1, 0, 0);
      set_vec( 5, 0, 32'h0000, 32'h3014, 32'h7F24, 4'hF, 1, 1, 0, 0);
      set_vec( 6, 0, 32'h0000, 32'h3014, 32'h7F20, 4'h0, 1, 1, 0, 0);
      set_vec( 7, 0, 32'h0000, 32'h3014, 32'h7F20, 4'hF, 0, 0, 1, 0);
      set_vec( 8, 0, 32'h0000, 32'h3014, 32'h7F20, 4'h1, 0, 0, 1, 1);
      set_vec( 9, 1, 32'h4000, 32'h4000, 32'h0000, 4'h0, 0, 1, 1, 1);
      set_vec(10, 1, 32'h4000, 32'h4000, 32'h0000, 4'h0, 0, 2, 1, 1);
      set_vec(11, 0, 32'h0000, 32'h4000, 32'h0000, 4'h0, 1, 2, 1, 1);
      set_vec(12, 0, 32'h0000, 32'h4000, 32'h7F20, 4'hF, 0, 1, 2, 1);
      set_vec(13, 0, 32'h0000, 32'h4000, 32'h0000, 4'h0, 1, 1, 2, 1);
      set_vec(14, 0, 32'h0000, 32'h4000, 32'h7F20, 4'hF, 0, 0, 3, 1);

      reset          = 1'b0;
      load_en        = 1'b0;
      load_pc        = '0;
      load_delay     = '0;
      macroscopic_pc = '0;
      m_int_addr     = '0;
      m_int_byteen   = '0;
      repeat (2) @(negedge clk);
      chk("rst_int", 32'(interrupt), 32'd0);
      chk("rst_cnt", 32'(pending_cnt), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd1);
      chk("rst_flags", {29'd0, overflow, spurious_ack, timeout}, 32'd0);
      chk("rst_ack_cnt", 32'(ack_cnt), 32'd0);
      reset = 1'b1;
      step();

      // Basic flow, acknowledge decoding and back-to-back re-fire.
      for (int i = 0; i < int'(NVEC); i++) begin
         load_en        = vecs[i].le;
         load_pc        = vecs[i].lpc;
         load_delay     = vecs[i].ld;
         macroscopic_pc = vecs[i].mpc;
         m_int_addr     = vecs[i].maddr;
         m_int_byteen   = vecs[i].mbe;
         step();
         chk($sformatf("vec%0d_int", i), 32'(interrupt), 32'(vecs[i].e_int));
         chk($sformatf("vec%0d_cnt", i), 32'(pending_cnt), 32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d_ack_cnt", i), 32'(ack_cnt), 32'(vecs[i].e_ack));
         chk($sformatf("vec%0d_ready", i), 32'(load_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
         chk($sformatf("vec%0d_spur", i), 32'(spurious_ack), 32'(vecs[i].e_spur));
      end
      load_en      = 1'b0;
      m_int_byteen = 4'b0000;

      // Delay of 5: interrupt exactly 5 edges after the match, PC ignored meanwhile.
      do_reset();
      macroscopic_pc = 32'h0;
      push(32'h3008, 16'd5);
      step();
      macroscopic_pc = 32'h3008;
      step();
      chk("dly5_k", 32'(interrupt), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         macroscopic_pc = 32'h3008 + 32'(i * 4);
         step();
         chk($sformatf("dly5_k%0d", i), 32'(interrupt), 32'd0);
      end
      step();
      chk("dly5_k5", 32'(interrupt), 32'd1);
      do_ack();
      chk("dly5_ack_int", 32'(interrupt), 32'd0);
      chk("dly5_ack_cnt", 32'(ack_cnt), 32'd1);

      // Delay of 1, then an asynchronous reset while asserted.
      macroscopic_pc = 32'h5000;
      push(32'h5000, 16'd1);
      step();
      chk("dly1_arm", 32'(interrupt), 32'd0);
      step();
      chk("dly1_match", 32'(interrupt), 32'd0);
      step();
      chk("dly1_fire", 32'(interrupt), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_assert_int", 32'(interrupt), 32'd0);
      chk("arst_assert_cnt", 32'(pending_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Overflow: fifth push into a 4-deep FIFO is dropped.
      macroscopic_pc = 32'hFFFF_0000;
      push(32'h100, 16'd0);
      chk("ovf_cnt1", 32'(pending_cnt), 32'd1);
      push(32'h104, 16'd50);
      push(32'h108, 16'd0);
      chk("ovf_ready3", 32'(load_ready), 32'd1);
      push(32'h10C, 16'd0);
      chk("ovf_ready4", 32'(load_ready), 32'd0);
      chk("ovf_cnt4", 32'(pending_cnt), 32'd4);
      chk("ovf_flag4", 32'(overflow), 32'd0);
      push(32'h110, 16'd0);
      chk("ovf_flag5", 32'(overflow), 32'd1);
      chk("ovf_cnt5", 32'(pending_cnt), 32'd4);

      // Timeout: withhold the acknowledge for MAX_WAIT cycles.
      macroscopic_pc = 32'h100;
      step();
      chk("to_fire", 32'(interrupt), 32'd1);
      macroscopic_pc = 32'hFFFF_0000;
      repeat (MAX_WAIT - 1) step();
      chk("to_before", 32'(timeout), 32'd0);
      step();
      chk("to_set", 32'(timeout), 32'd1);
      chk("to_int", 32'(interrupt), 32'd1);
      do_ack();
      chk("to_ack_int", 32'(interrupt), 32'd0);
      chk("to_ack_cnt", 32'(ack_cnt), 32'd1);
      chk("to_pending", 32'(pending_cnt), 32'd3);
      chk("to_sticky", 32'(timeout), 32'd1);

      // Asynchronous reset mid-cycle during DELAY with 3 entries queued.
      macroscopic_pc = 32'h104;
      step();
      macroscopic_pc = 32'hFFFF_0000;
      step();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_int", 32'(interrupt), 32'd0);
      chk("arst_cnt", 32'(pending_cnt), 32'd0);
      chk("arst_ready", 32'(load_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_flags", {29'd0, overflow, spurious_ack, timeout}, 32'd0);
      chk("arst_ack_cnt", 32'(ack_cnt), 32'd0);

      // Sequencer restarts from IDLE: push, arm, then fire on the third edge.
      macroscopic_pc = 32'h700;
      push(32'h700, 16'd0);
      chk("idle_push", 32'(interrupt), 32'd0);
      step();
      chk("idle_arm", 32'(interrupt), 32'd0);
      step();
      chk("idle_fire", 32'(interrupt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
